// File: rtl/aucohl_fifo_th_if.sv
// Bus-side bundle for aucohl_fifo_th: data strobes, status and threshold/error controls.
// The master drives strobes and thresholds; the slave (the FIFO) returns data and status.
interface aucohl_fifo_th_if #(
   parameter int DW = 8,
   parameter int AW = 4
);
   logic          flush;
   logic          wr;
   logic [DW-1:0] wdata;
   logic          rd;
   logic [DW-1:0] rdata;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic [AW:0]   afull_th;
   logic [AW:0]   aempty_th;
   logic          afull;
   logic          aempty;
   logic          clr_err;
   logic          overflow;
   logic          underflow;

   modport master (
      output flush, wr, wdata, rd, afull_th, aempty_th, clr_err,
      input  rdata, full, empty, level, afull, aempty, overflow, underflow
   );

   modport slave (
      input  flush, wr, wdata, rd, afull_th, aempty_th, clr_err,
      output rdata, full, empty, level, afull, aempty, overflow, underflow
   );
endinterface

// File: rtl/aucohl_fifo_th.sv
// Show-ahead synchronous FIFO with a registered level counter, runtime almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module aucohl_fifo_th #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic                clk,
   input  logic                rst,
   aucohl_fifo_th_if.slave     bus
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] LVL_FULL = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_overflow;
   logic          r_underflow;

   logic          w_full;
   logic          w_empty;
   logic          w_wr_ok;
   logic          w_rd_ok;
   logic          w_ovf_set;
   logic          w_unf_set;

   assign w_full  = (r_level == LVL_FULL);
   assign w_empty = (r_level == '0);

   // A write into a full FIFO is only accepted when a pop frees the slot in the same cycle.
   // Flush discards both strobes and suppresses any error they would have raised.
   assign w_wr_ok   = bus.wr & (~w_full | bus.rd) & ~bus.flush;
   assign w_rd_ok   = bus.rd & ~w_empty & ~bus.flush;
   assign w_ovf_set = bus.wr & w_full & ~bus.rd & ~bus.flush;
   assign w_unf_set = bus.rd & w_empty & ~bus.flush;

   always_ff @(posedge clk) begin
      if (w_wr_ok && !rst) begin
         r_mem[r_wr_ptr] <= bus.wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= r_level + {{AW{1'b0}}, w_wr_ok} - {{AW{1'b0}}, w_rd_ok};
      end
   end

   // Setting an error wins over clearing it in the same cycle; flush leaves the flags alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= w_ovf_set | (r_overflow & ~bus.clr_err);
         r_underflow <= w_unf_set | (r_underflow & ~bus.clr_err);
      end
   end

   assign bus.rdata     = r_mem[r_rd_ptr];
   assign bus.full      = w_full;
   assign bus.empty     = w_empty;
   assign bus.level     = r_level;
   assign bus.afull     = (r_level >= bus.afull_th);
   assign bus.aempty    = (r_level <= bus.aempty_th);
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_aucohl_fifo_th.sv
// Directed bench for aucohl_fifo_th: popped data checked by a scoreboard monitor,
// level/flag/threshold status checked against hand-derived constants.
module tb_aucohl_fifo_th;
   localparam int DW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;
   int mdl_lvl = 0;
   logic [DW-1:0] exp_q[$];

   aucohl_fifo_th_if #(.DW(DW), .AW(AW)) bus ();

   aucohl_fifo_th #(.DW(DW), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the bench-side model decides what the FIFO should accept.
   task automatic op(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
      bit w_ok, r_ok;
      bus.wr = w; bus.wdata = d; bus.rd = r; bus.flush = f;
      w_ok = w && (mdl_lvl < 16 || r) && !f;
      r_ok = r && (mdl_lvl > 0) && !f;
      if (f) begin
         exp_q.delete();
         mdl_lvl = 0;
      end else begin
         if (w_ok) exp_q.push_back(d);
         mdl_lvl = mdl_lvl + int'(w_ok) - int'(r_ok);
      end
      @(posedge clk); #1;
      bus.wr = 1'b0; bus.rd = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic clr();
      bus.clr_err = 1'b1;
      @(posedge clk); #1;
      bus.clr_err = 1'b0;
   endtask

   // Monitor: every accepted pop presents a head entry that must match the scoreboard.
   always @(negedge clk) begin
      if (!rst && !bus.flush && bus.rd && !bus.empty) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underrun: got %0h with no entry expected", bus.rdata);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (bus.rdata !== e) begin
               errors++;
               $display("FAIL sb_rdata: got %0h expected %0h at %0t", bus.rdata, e, $time);
            end
         end
      end
   end

   initial begin
      bus.flush = 0; bus.wr = 0; bus.wdata = '0; bus.rd = 0; bus.clr_err = 0;
      bus.afull_th = 5'd12; bus.aempty_th = 5'd3;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_level", bus.level, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_unf", bus.underflow, 0);
      chk("rst_afull", bus.afull, 0);
      chk("rst_aempty", bus.aempty, 1);

      // Fill 0x00..0x0F, ramping level up through both thresholds.
      for (int i = 0; i < 16; i++) begin
         op(1'b1, DW'(i), 1'b0, 1'b0);
         chk("fill_level", bus.level, i + 1);
         chk("fill_afull", bus.afull, (i + 1) >= 12);
         chk("fill_aempty", bus.aempty, (i + 1) <= 3);
         chk("fill_full", bus.full, (i == 15));
      end
      op(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovf_set", bus.overflow, 1);
      chk("ovf_level", bus.level, 16);

      // Drain; the monitor checks 0x00..0x0F order.
      for (int i = 0; i < 16; i++) begin
         op(1'b0, '0, 1'b1, 1'b0);
         chk("drain_level", bus.level, 15 - i);
         chk("drain_afull", bus.afull, (15 - i) >= 12);
         chk("drain_aempty", bus.aempty, (15 - i) <= 3);
      end
      chk("drain_empty", bus.empty, 1);
      op(1'b0, '0, 1'b1, 1'b0);
      chk("unf_set", bus.underflow, 1);
      chk("unf_level", bus.level, 0);
      clr();
      chk("clr_ovf", bus.overflow, 0);
      chk("clr_unf", bus.underflow, 0);

      // Full FIFO streaming through pointer wrap.
      for (int i = 0; i < 16; i++) op(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
      bus.aempty_th = 5'd16; #1;
      chk("aempty_th_max", bus.aempty, 1);
      bus.aempty_th = 5'd15; #1;
      chk("aempty_th_15", bus.aempty, 0);
      bus.aempty_th = 5'd3;
      for (int i = 0; i < 20; i++) begin
         op(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
         chk("stream_level", bus.level, 16);
      end
      chk("stream_ovf", bus.overflow, 0);
      for (int i = 0; i < 16; i++) op(1'b0, '0, 1'b1, 1'b0);
      chk("stream_empty", bus.empty, 1);

      // Simultaneous wr&rd on an empty FIFO.
      op(1'b1, 8'hA5, 1'b1, 1'b0);
      chk("emptywr_level", bus.level, 1);
      chk("emptywr_rdata", bus.rdata, 8'hA5);
      chk("emptywr_unf", bus.underflow, 1);
      clr();
      op(1'b0, '0, 1'b1, 1'b0);
      chk("pop_a5_level", bus.level, 0);

      // Threshold edges at level 0, changes visible the same cycle.
      bus.afull_th = 5'd0; #1;
      chk("afull_th0", bus.afull, 1);
      bus.afull_th = 5'd1; #1;
      chk("afull_th1", bus.afull, 0);
      bus.afull_th = 5'd12;

      // Flush at level 9 with a concurrent write.
      for (int i = 0; i < 9; i++) op(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
      chk("pre_flush_level", bus.level, 9);
      op(1'b1, 8'h77, 1'b0, 1'b1);
      chk("flush_level", bus.level, 0);
      chk("flush_empty", bus.empty, 1);
      chk("flush_ovf", bus.overflow, 0);
      chk("flush_unf", bus.underflow, 0);

      // Sticky flag then async reset mid-fill.
      op(1'b0, '0, 1'b1, 1'b0);
      chk("post_flush_unf", bus.underflow, 1);
      for (int i = 0; i < 5; i++) op(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
      chk("prerst_level", bus.level, 5);
      #3 rst = 1'b1;
      #1;
      chk("arst_level", bus.level, 0);
      chk("arst_empty", bus.empty, 1);
      chk("arst_full", bus.full, 0);
      chk("arst_unf", bus.underflow, 0);
      chk("arst_aempty", bus.aempty, 1);
      exp_q.delete();
      mdl_lvl = 0;
      @(posedge clk); #1 rst = 1'b0;
      op(1'b1, 8'h3C, 1'b0, 1'b0);
      op(1'b0, '0, 1'b1, 1'b0);
      chk("postrst_level", bus.level, 0);

      chk("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
